// File: rtl/sprite_pos_writer.sv
// Sprite-position writer: snapshots up to six 16-bit position words and writes
// the masked ones, in ascending index order, into a six-word memory block.
// It pulses done and counts each completed set.
module sprite_pos_writer #(
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] mx_in,
  input  logic [15:0] my_in,
  input  logic [15:0] p1x_in,
  input  logic [15:0] p1y_in,
  input  logic [15:0] p2x_in,
  input  logic [15:0] p2y_in,
  input  logic [5:0]  load_mask,
  input  logic        mem_grant,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        done,
  output logic [15:0] update_count
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  mask_q, mask_d;
  logic [15:0] word_q [6];
  logic [15:0] word_d [6];
  logic [15:0] count_q, count_d;

  // Mask bits strictly above the current index, used to find the next word.
  logic [5:0]  above_mask;
  logic [5:0]  remaining;

  // Index of the lowest set bit; callers only use it when v is non-zero.
  function automatic logic [2:0] lowest_bit(input logic [5:0] v);
    lowest_bit = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (v[i]) lowest_bit = 3'(i);
    end
  endfunction

  // Select the mask bits that have not been written yet.
  always_comb begin
    above_mask = '0;
    for (int i = 0; i < 6; i++) begin
      above_mask[i] = (3'(i) > idx_q);
    end
    remaining = mask_q & above_mask;
  end

  // Next-state logic: accept, walk the masked words, then retire the set.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    word_d  = word_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          mask_d    = load_mask;
          word_d[0] = mx_in;
          word_d[1] = my_in;
          word_d[2] = p1x_in;
          word_d[3] = p1y_in;
          word_d[4] = p2x_in;
          word_d[5] = p2y_in;
          if (load_mask != 6'd0) begin
            state_d = StWrite;
            idx_d   = lowest_bit(load_mask);
          end else begin
            state_d = StDone;
          end
        end
      end
      StWrite: begin
        if (mem_grant) begin
          if (remaining != 6'd0) begin
            idx_d = lowest_bit(remaining);
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        count_d = count_q + 16'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      mask_q  <= 6'd0;
      count_q <= 16'd0;
      for (int i = 0; i < 6; i++) begin
        word_q[i] <= 16'd0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      for (int i = 0; i < 6; i++) begin
        word_q[i] <= word_d[i];
      end
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    mem_we       = 1'b0;
    mem_addr     = BASE_ADDR;
    mem_data     = 16'd0;
    load_ready   = (state_q == StIdle);
    done         = (state_q == StDone);
    update_count = count_q;
    if (state_q == StWrite) begin
      mem_we   = 1'b1;
      mem_addr = BASE_ADDR + {13'd0, idx_q};
      mem_data = word_q[idx_q];
    end
  end

endmodule

// File: tb/tb_sprite_pos_writer.sv
// Self-checking bench for sprite_pos_writer: directed sets plus random sets,
// each compared against an expected queue of (index) writes built from the mask.
module tb_sprite_pos_writer;

  localparam logic [15:0] BASE = 16'hFFFC;  // BASE+4, BASE+5 wrap past 16'hFFFF

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] mx_in, my_in, p1x_in, p1y_in, p2x_in, p2y_in;
  logic [5:0]  load_mask;
  logic        mem_grant;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        done;
  logic [15:0] update_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = 16'd0;

  sprite_pos_writer #(.BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .mx_in        (mx_in),
    .my_in        (my_in),
    .p1x_in       (p1x_in),
    .p1y_in       (p1y_in),
    .p2x_in       (p2x_in),
    .p2y_in       (p2y_in),
    .load_mask    (load_mask),
    .mem_grant    (mem_grant),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .done         (done),
    .update_count (update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_words(input logic [5:0][15:0] w);
    mx_in  = w[0];
    my_in  = w[1];
    p1x_in = w[2];
    p1y_in = w[3];
    p2x_in = w[4];
    p2y_in = w[5];
  endtask

  task automatic scramble_inputs();
    mx_in     = 16'($urandom);
    my_in     = 16'($urandom);
    p1x_in    = 16'($urandom);
    p1y_in    = 16'($urandom);
    p2x_in    = 16'($urandom);
    p2y_in    = 16'($urandom);
    load_mask = 6'($urandom);
  endtask

  // mode 0: grant always high; 1: random grant; 2: stall index 2 for three cycles.
  task automatic run_set(input logic [5:0][15:0] w, input logic [5:0] m, input int mode,
                         input bit hold);
    int q[$];
    int cycles;
    int stall;
    logic g;
    cycles = 0;
    while (!load_ready && cycles < 50) begin
      tick();
      cycles++;
    end
    check("ready_before_accept", 16'(load_ready), 16'd1);
    drive_words(w);
    load_mask  = m;
    load_valid = 1'b1;
    mem_grant  = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (m[i]) q.push_back(i);
    end
    scramble_inputs();
    load_valid = hold;
    cycles = 0;
    stall  = 0;
    while (q.size() > 0 && cycles < 200) begin
      check("ready_busy", 16'(load_ready), 16'd0);
      check("we", 16'(mem_we), 16'd1);
      check("addr", mem_addr, 16'(BASE + 16'(q[0])));
      check("data", mem_data, w[q[0]]);
      check("done_busy", 16'(done), 16'd0);
      case (mode)
        0: g = 1'b1;
        1: g = (cycles > 100) ? 1'b1 : 1'($urandom_range(0, 1));
        default: begin
          if (q[0] == 2 && stall < 3) begin
            g = 1'b0;
            stall++;
          end else begin
            g = 1'b1;
          end
        end
      endcase
      mem_grant = g;
      if (hold) scramble_inputs();
      tick();
      cycles++;
      if (g) void'(q.pop_front());
    end
    check("writes_left", 16'(q.size()), 16'd0);
    if (mode == 0) check("write_cycles", 16'(cycles), 16'($countones(m)));
    if (mode == 2 && m[2]) check("stall_cycles", 16'(stall), 16'd3);
    load_valid = 1'b0;
    mem_grant  = 1'($urandom_range(0, 1));
    check("done_pulse", 16'(done), 16'd1);
    check("we_in_done", 16'(mem_we), 16'd0);
    check("ready_in_done", 16'(load_ready), 16'd0);
    check("count_in_done", update_count, exp_count);
    tick();
    exp_count = exp_count + 16'd1;
    check("done_clear", 16'(done), 16'd0);
    check("ready_after", 16'(load_ready), 16'd1);
    check("count_after", update_count, exp_count);
    check("idle_we", 16'(mem_we), 16'd0);
    check("idle_addr", mem_addr, BASE);
    check("idle_data", mem_data, 16'd0);
  endtask

  initial begin
    logic [5:0][15:0] w;
    reset      = 1'b0;
    load_valid = 1'b0;
    mem_grant  = 1'b0;
    load_mask  = 6'd0;
    drive_words('0);
    tick();
    tick();
    check("rst_ready", 16'(load_ready), 16'd1);
    check("rst_we", 16'(mem_we), 16'd0);
    check("rst_addr", mem_addr, BASE);
    check("rst_data", mem_data, 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_count", update_count, 16'd0);
    reset = 1'b1;
    tick();

    // Full set with grant tied high.
    for (int i = 0; i < 6; i++) w[i] = 16'(16'h0010 * (i + 1));
    run_set(w, 6'h3F, 0, 1'b0);
    // Sparse mask: indices 0, 2, 5.
    for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
    run_set(w, 6'b100101, 0, 1'b0);
    // Grant withheld three cycles on index 2.
    for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
    run_set(w, 6'b011110, 2, 1'b0);
    // Empty mask goes straight to done.
    run_set(w, 6'd0, 0, 1'b0);
    // load_valid held high with changing data during the write.
    for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
    run_set(w, 6'h3F, 1, 1'b1);

    // Reset while index 3 is being written.
    for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
    drive_words(w);
    load_mask  = 6'h3F;
    load_valid = 1'b1;
    mem_grant  = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_addr", mem_addr, 16'(BASE + 16'd3));
    check("pre_rst_data", mem_data, w[3]);
    reset      = 1'b0;
    load_valid = 1'b1;
    tick();
    check("midrst_we", 16'(mem_we), 16'd0);
    check("midrst_ready", 16'(load_ready), 16'd1);
    check("midrst_count", update_count, 16'd0);
    check("midrst_done", 16'(done), 16'd0);
    reset      = 1'b1;
    load_valid = 1'b0;
    tick();
    check("postrst_done", 16'(done), 16'd0);
    check("postrst_we", 16'(mem_we), 16'd0);
    check("postrst_count", update_count, 16'd0);
    exp_count = 16'd0;

    // Random sets with random grant and occasional held load_valid.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
      run_set(w, 6'($urandom), 1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_pos_writer.md
SPRITE_POS_WRITER -- requirements
Module: sprite_pos_writer

Interface
REQ-001 Parameter: BASE_ADDR, 16'h0000, address of word 0 (mx) of the six-word sprite-position block in shared memory.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset.
REQ-004 Port: load_valid  input  1  producer offers a new position set.
REQ-005 Port: load_ready  output  1  block can accept a set (high only in IDLE).
REQ-006 Port: mx_in, my_in, p1x_in, p1y_in, p2x_in, p2y_in  input  16 each  new position words.
REQ-007 Port: load_mask  input  6  per-word write enable; bit i selects word i (0 mx, 1 my, 2 p1x, 3 p1y, 4 p2x, 5 p2y).
REQ-008 Port: mem_grant  input  1  memory accepts a write this cycle.
REQ-009 Port: mem_we  output  1  write request.
REQ-010 Port: mem_addr  output  16  write address, BASE_ADDR + word index.
REQ-011 Port: mem_data  output  16  write data.
REQ-012 Port: done  output  1  one-cycle pulse when a set has been fully written.
REQ-013 Port: update_count  output  16  number of completed sets, wraps modulo 2^16.

Function
REQ-014 FSM states: IDLE, WRITE, DONE; encoding free.
REQ-015 Handshake: a set is accepted on a rising edge where load_valid && load_ready; six data words and load_mask are snapshotted that edge.
REQ-016 load_valid while not IDLE is ignored; no input is sampled.
REQ-017 Accept with load_mask != 0: next state WRITE, index = lowest set mask bit.
REQ-018 Accept with load_mask == 0: next state DONE; no memory write issued.
REQ-019 In WRITE: mem_we = 1, mem_addr = BASE_ADDR + index (16-bit wrap), mem_data = snapshot word[index]; all combinational from registered state.
REQ-020 A write completes on an edge where mem_we && mem_grant; index advances to next higher set mask bit; if none remain, next state DONE.
REQ-021 mem_grant low: state, index, mem_addr, mem_data, mem_we held unchanged; no timeout.
REQ-022 Words are written strictly in ascending index order; unmasked words are skipped with zero cycles spent.
REQ-023 In DONE: done = 1 for exactly one cycle, update_count increments by 1 (16'hFFFF -> 16'h0000), next state IDLE.
REQ-024 Outside WRITE: mem_we = 0, mem_addr = BASE_ADDR, mem_data = 0.
REQ-025 Latency, full mask, mem_grant tied high: accept edge E; writes complete on edges E+1..E+6; done high in cycle after E+6; load_ready high again one cycle later.
REQ-026 Snapshot registers are not altered by input changes after acceptance.

Reset
REQ-027 reset low at a rising edge: state IDLE, index 0, snapshot words 0, mask 0, update_count 0.
REQ-028 Post-reset outputs: load_ready 1, mem_we 0, mem_addr BASE_ADDR, mem_data 0, done 0.
REQ-029 Reset mid-WRITE abandons the set: mem_we 0 from the cycle after the reset edge, no done pulse, update_count 0.
REQ-030 reset has priority over every other input including load_valid and mem_grant.

Verification
REQ-031 Full set, mem_grant = 1: load mx=16'h0010, my=16'h0020, p1x=16'h0030, p1y=16'h0040, p2x=16'h0050, p2y=16'h0060, mask 6'h3F -> writes to BASE+0..BASE+5 with those data on six consecutive cycles, one done pulse, update_count 1.
REQ-032 Sparse mask 6'b100101 -> exactly three writes, addresses BASE+0, BASE+2, BASE+5, in that order, done after third.
REQ-033 mem_grant low for 3 cycles during write of index 2 -> mem_addr BASE+2 and data held 3 cycles, no duplicate or skipped write.
REQ-034 Mask 0 -> no mem_we, done pulse one cycle after accept, update_count increments.
REQ-035 load_valid held high with changed data during WRITE -> not sampled; memory receives original snapshot; next set accepted only after return to IDLE.
REQ-036 reset low during WRITE at index 3 -> mem_we 0 next cycle, no done, update_count 0, load_ready 1.
